// File: rtl/digest_serializer.sv
// Unpacks a wide hash digest into a byte stream for a UART transmitter,
// either as raw bytes or lowercase ASCII hex, with an optional CR LF trailer.
module digest_serializer #(
  parameter int DIGEST_BITS = 512,
  parameter int HEX         = 1,
  parameter int EOL         = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DIGEST_BITS-1:0] digest,
  input  logic                   digest_valid,
  output logic                   digest_ack,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy
);

  localparam int N  = (HEX != 0) ? DIGEST_BITS / 4 : DIGEST_BITS / 8;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int SH = (HEX != 0) ? 4 : 8;

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, TERM = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [DIGEST_BITS-1:0] sr_q, sr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   term_q, term_d;
  logic                   xfer_s;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    hex_char = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  assign tx_valid   = (state_q != IDLE);
  assign busy       = (state_q != IDLE);
  assign xfer_s     = tx_valid & tx_ready;
  assign digest_ack = (state_q == IDLE) & digest_valid & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      term_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      term_q  <= term_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    term_d  = term_q;
    tx_data = 8'h00;
    case (state_q)
      IDLE: begin
        if (digest_valid) begin
          sr_d    = digest;
          cnt_d   = CW'(N - 1);
          state_d = SEND;
        end
      end
      SEND: begin
        tx_data = (HEX != 0) ? hex_char(sr_q[DIGEST_BITS-1 -: 4]) : sr_q[DIGEST_BITS-1 -: 8];
        if (xfer_s) begin
          sr_d = sr_q << SH;
          // The final character leaves cnt at zero rather than wrapping.
          if (cnt_q == '0) begin
            term_d  = 1'b0;
            state_d = (EOL != 0) ? TERM : IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      TERM: begin
        tx_data = term_q ? 8'h0A : 8'h0D;
        if (xfer_s) begin
          if (term_q) begin
            term_d  = 1'b0;
            state_d = IDLE;
          end else begin
            term_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_digest_serializer.sv
// Randomized bench: a hex+CRLF instance and a raw no-trailer instance checked
// every cycle against a queue-based model of the expected character stream.
module tb_digest_serializer;

  logic         clk = 1'b0;
  logic         reset;
  logic         dv   [2];
  logic         rdy  [2];
  logic [511:0] dg   [2];
  logic         ack  [2];
  logic         txv  [2];
  logic         bsy  [2];
  logic [7:0]   txd  [2];

  int total = 0;
  int bad   = 0;

  byte unsigned expq [2][$];
  byte unsigned bld  [$];

  always #5 clk = ~clk;

  digest_serializer #(.DIGEST_BITS(512), .HEX(1), .EOL(1)) u_hex (
    .clk(clk), .reset(reset), .digest(dg[0]), .digest_valid(dv[0]), .digest_ack(ack[0]),
    .tx_data(txd[0]), .tx_valid(txv[0]), .tx_ready(rdy[0]), .busy(bsy[0]));

  digest_serializer #(.DIGEST_BITS(512), .HEX(0), .EOL(0)) u_raw (
    .clk(clk), .reset(reset), .digest(dg[1]), .digest_valid(dv[1]), .digest_ack(ack[1]),
    .tx_data(txd[1]), .tx_valid(txv[1]), .tx_ready(rdy[1]), .busy(bsy[1]));

  function automatic byte unsigned hexc(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(97 + n - 10);
  endfunction

  // Expected character stream for one captured digest.
  function automatic void build(input logic [511:0] d, input bit hex, input bit eol);
    byte unsigned b;
    bld.delete();
    for (int k = 0; k < 64; k++) begin
      b = d[511 - 8*k -: 8];
      if (hex) begin
        bld.push_back(hexc(int'(b) / 16));
        bld.push_back(hexc(int'(b) % 16));
      end else begin
        bld.push_back(b);
      end
    end
    if (eol) begin
      bld.push_back(8'h0D);
      bld.push_back(8'h0A);
    end
  endfunction

  function automatic void chk(input string name, input int i, input logic [31:0] got,
                              input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h", name, i, got, want);
    end
  endfunction

  // The model decides at each falling edge what the next rising edge does.
  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        chk("rst_valid", i, 32'(txv[i]), 32'd0);
        chk("rst_busy",  i, 32'(bsy[i]), 32'd0);
        chk("rst_ack",   i, 32'(ack[i]), 32'd0);
        chk("rst_data",  i, 32'(txd[i]), 32'd0);
        expq[i].delete();
      end else if (expq[i].size() != 0) begin
        chk("valid", i, 32'(txv[i]), 32'd1);
        chk("busy",  i, 32'(bsy[i]), 32'd1);
        chk("ack",   i, 32'(ack[i]), 32'd0);
        chk("data",  i, 32'(txd[i]), 32'(expq[i][0]));
        if (rdy[i]) void'(expq[i].pop_front());
      end else begin
        chk("idle_valid", i, 32'(txv[i]), 32'd0);
        chk("idle_busy",  i, 32'(bsy[i]), 32'd0);
        chk("idle_ack",   i, 32'(ack[i]), 32'(dv[i]));
        if (dv[i]) begin
          build(dg[i], i == 0, i == 0);
          expq[i] = bld;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int i, input int bound);
    int n = 0;
    while (bsy[i] && n < bound) begin
      step();
      n++;
    end
    chk("idle_timeout", i, 32'(bsy[i]), 32'd0);
  endtask

  function automatic logic [511:0] rnd_digest();
    logic [511:0] d;
    for (int j = 0; j < 16; j++) d[32*j +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    int n;
    logic [511:0] d;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      dv[i] = 1'b0; rdy[i] = 1'b0; dg[i] = '0;
    end

    // Hand-computed pins on the model itself.
    d = '0; d[511 -: 16] = 16'hA53C;
    build(d, 1'b1, 1'b1);
    chk("pin_len", -1, 32'(bld.size()), 32'd130);
    chk("pin_c0", -1, 32'(bld[0]), 32'h61);
    chk("pin_c1", -1, 32'(bld[1]), 32'h35);
    chk("pin_c2", -1, 32'(bld[2]), 32'h33);
    chk("pin_c3", -1, 32'(bld[3]), 32'h63);
    chk("pin_c127", -1, 32'(bld[127]), 32'h30);
    chk("pin_cr", -1, 32'(bld[128]), 32'h0D);
    chk("pin_lf", -1, 32'(bld[129]), 32'h0A);
    d = '0; d[511 -: 8] = 8'h9A;
    build(d, 1'b1, 1'b0);
    chk("pin_9", -1, 32'(bld[0]), 32'h39);
    chk("pin_a", -1, 32'(bld[1]), 32'h61);
    chk("pin_rawlen", -1, 32'(bld.size()), 32'd128);

    fork
      forever begin
        @(negedge clk);
        compare();
      end
    join_none

    repeat (3) step();
    reset = 1'b0;
    step();

    // Hex stream with CR LF, no stall: 130 consecutive transfers.
    dg[0] = '0; dg[0][511 -: 16] = 16'hA53C; dv[0] = 1'b1; rdy[0] = 1'b1;
    step();
    dv[0] = 1'b0;
    n = 0;
    while (bsy[0] && n < 300) begin
      if (txv[0] && rdy[0]) n++;
      step();
    end
    chk("hex_xfers", 0, 32'(n), 32'd130);

    // Raw ascending bytes, no trailer.
    for (int k = 0; k < 64; k++) dg[1][511 - 8*k -: 8] = 8'(k);
    dv[1] = 1'b1; rdy[1] = 1'b1;
    step();
    dv[1] = 1'b0;
    n = 0;
    while (bsy[1] && n < 300) begin
      if (txv[1] && rdy[1]) n++;
      step();
    end
    chk("raw_xfers", 1, 32'(n), 32'd64);

    // Backpressure: ready pattern 1,0,0 repeating, plus the 0x9A nibble boundary.
    dg[0] = rnd_digest(); dg[0][511 -: 8] = 8'h9A; dv[0] = 1'b1;
    step();
    dv[0] = 1'b0;
    n = 0;
    while (bsy[0] && n < 1000) begin
      rdy[0] = (n % 3 == 0);
      step();
      n++;
    end
    chk("stall_done", 0, 32'(bsy[0]), 32'd0);

    // Overlap: digest_valid held high across a full stream and into a second capture.
    rdy[0] = 1'b1; dg[0] = rnd_digest(); dv[0] = 1'b1;
    step();
    dg[0] = rnd_digest();
    repeat (140) step();
    dv[0] = 1'b0;
    wait_idle(0, 300);

    // Reset after 10 transfers aborts at once; capture resumes only after release.
    dg[0] = rnd_digest(); dv[0] = 1'b1;
    step();
    dv[0] = 1'b0;
    repeat (10) step();
    reset = 1'b1; dv[0] = 1'b1; dg[0] = rnd_digest();
    #1;
    chk("abort_valid", 0, 32'(txv[0]), 32'd0);
    chk("abort_busy",  0, 32'(bsy[0]), 32'd0);
    step();
    step();
    reset = 1'b0;
    step();
    dv[0] = 1'b0;
    wait_idle(0, 300);

    // Random traffic on both instances.
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 600; c++) begin
        for (int i = 0; i < 2; i++) begin
          rdy[i] = 1'($urandom_range(0, 1));
          dv[i]  = ($urandom_range(0, 7) == 0);
          if (dv[i]) dg[i] = rnd_digest();
        end
        step();
      end
      for (int i = 0; i < 2; i++) begin
        dv[i] = 1'b0; rdy[i] = 1'b1;
      end
      wait_idle(0, 400);
      wait_idle(1, 400);
    end

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
